// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio: memory-mapped UART transmitter with a byte-wide TX FIFO.
//
// Register window (8 bytes at MMIO_BASE):
//   +0 TXDATA  write lane 0 pushes a byte; reads return 0
//   +4 STATUS  [0] full, [1] empty, [2] frame active, [3] sticky overflow,
//              [15:8] FIFO count; writing lane 0 with bit 3 set clears overflow
// Stores that hit the window are not forwarded to the data RAM.
//
// Build option: define UART_TX_PARITY_EN to insert an even-parity bit between
// the data bits and the stop bit (11-bit frame instead of 10).

module uart_tx_mmio #(
   parameter logic [31:0] MMIO_BASE    = 32'hFFFF_0000,
   parameter int unsigned CLKS_PER_BIT = 16,
   parameter int unsigned FIFO_DEPTH   = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [3:0]  mem_we,
   input  logic [31:0] mem_write_addr,
   input  logic [31:0] mem_write_data,
   input  logic [31:0] mem_read1_addr,
   input  logic [31:0] ram_read1_data,
   output logic [31:0] mem_read1_data,
   output logic [3:0]  ram_we,
   output logic        uart_tx,
   output logic        tx_busy
);

   localparam int unsigned    PtrW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned    CntW     = $clog2(FIFO_DEPTH + 1);
   localparam logic [CntW-1:0] CntFull = CntW'(FIFO_DEPTH);
   localparam logic [15:0]    BaudLast = 16'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      StIdle   = 3'd0,
      StStart  = 3'd1,
      StData   = 3'd2,
`ifdef UART_TX_PARITY_EN
      StParity = 3'd3,
`endif
      StStop   = 3'd4
   } tx_state_e;

   // ---------------------------------------------------------------------------
   // Reset release synchronisation
   // ---------------------------------------------------------------------------
   logic ready_q;

   // Pushes are held off until one clock edge after rst_n rises, so the first
   // store that can land is the one sampled on the second edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ready_q <= 1'b0;
      end else begin
         ready_q <= 1'b1;
      end
   end

   // ---------------------------------------------------------------------------
   // Address decode
   // ---------------------------------------------------------------------------
   logic wr_mmio;
   logic rd_mmio;
   logic push_req;
   logic push_ok;
   logic ovf_clr;
   logic pop;

   assign wr_mmio  = (mem_write_addr[31:3] == MMIO_BASE[31:3]);
   assign rd_mmio  = (mem_read1_addr[31:3] == MMIO_BASE[31:3]);
   assign ram_we   = wr_mmio ? 4'b0000 : mem_we;
   assign push_req = ready_q && wr_mmio && !mem_write_addr[2] && mem_we[0];
   assign ovf_clr  = wr_mmio && mem_write_addr[2] && mem_we[0] && mem_write_data[3];

   // Upper data lanes and byte offsets inside a word play no part in decode.
   logic unused_bits;
   assign unused_bits = ^{mem_write_data[31:8], mem_write_addr[1:0], mem_read1_addr[1:0]};

   // ---------------------------------------------------------------------------
   // TX FIFO
   // ---------------------------------------------------------------------------
   logic [7:0]      fifo_mem_q [FIFO_DEPTH];
   logic [PtrW-1:0] wr_ptr_q;
   logic [PtrW-1:0] rd_ptr_q;
   logic [CntW-1:0] count_q;
   logic            fifo_full;
   logic            fifo_empty;
   logic [7:0]      fifo_rdata;
   logic            ovf_q;

   assign fifo_full  = (count_q == CntFull);
   assign fifo_empty = (count_q == '0);
   assign fifo_rdata = fifo_mem_q[rd_ptr_q];
   // A full FIFO still takes a byte when the transmitter frees a slot this cycle.
   assign push_ok    = push_req && (!fifo_full || pop);

   // FIFO storage, data only; validity is tracked by the pointers and count.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         fifo_mem_q[wr_ptr_q] <= mem_write_data[7:0];
      end
   end

   // FIFO pointers wrap naturally at the power-of-two depth; count spans 0..depth.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr_q <= wr_ptr_q + PtrW'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PtrW'(1);
         end
         case ({push_ok, pop})
            2'b10:   count_q <= count_q + CntW'(1);
            2'b01:   count_q <= count_q - CntW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Sticky overflow: set by a dropped push, cleared only by software.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_q <= 1'b0;
      end else if (ovf_clr) begin
         ovf_q <= 1'b0;
      end else if (push_req && fifo_full && !pop) begin
         ovf_q <= 1'b1;
      end
   end

   // ---------------------------------------------------------------------------
   // Transmitter
   // ---------------------------------------------------------------------------
   tx_state_e   state_q, state_d;
   logic [15:0] baud_q, baud_d;
   logic [2:0]  bit_q, bit_d;
   logic [7:0]  shift_q, shift_d;
   logic        tx_q, tx_d;
   logic        baud_last;
`ifdef UART_TX_PARITY_EN
   logic        parity_q, parity_d;
`endif

   assign baud_last = (baud_q == BaudLast);

   // Transmitter state register; uart_tx is registered so the line never glitches.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         baud_q   <= '0;
         bit_q    <= '0;
         shift_q  <= '0;
         tx_q     <= 1'b1;
`ifdef UART_TX_PARITY_EN
         parity_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         baud_q   <= baud_d;
         bit_q    <= bit_d;
         shift_q  <= shift_d;
         tx_q     <= tx_d;
`ifdef UART_TX_PARITY_EN
         parity_q <= parity_d;
`endif
      end
   end

   // Next-state logic; a byte is popped from IDLE or at the end of STOP.
   always_comb begin
      state_d  = state_q;
      baud_d   = baud_q;
      bit_d    = bit_q;
      shift_d  = shift_q;
      pop      = 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_d = parity_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (!fifo_empty) begin
               pop = 1'b1;
            end
         end
         StStart: begin
            if (baud_last) begin
               baud_d  = '0;
               bit_d   = '0;
               state_d = StData;
            end else begin
               baud_d = baud_q + 16'd1;
            end
         end
         StData: begin
            if (baud_last) begin
               baud_d = '0;
               if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  state_d = StParity;
`else
                  state_d = StStop;
`endif
               end else begin
                  bit_d   = bit_q + 3'd1;
                  shift_d = {1'b0, shift_q[7:1]};
               end
            end else begin
               baud_d = baud_q + 16'd1;
            end
         end
`ifdef UART_TX_PARITY_EN
         StParity: begin
            if (baud_last) begin
               baud_d  = '0;
               state_d = StStop;
            end else begin
               baud_d = baud_q + 16'd1;
            end
         end
`endif
         StStop: begin
            if (baud_last) begin
               baud_d = '0;
               if (!fifo_empty) begin
                  pop = 1'b1;
               end else begin
                  state_d = StIdle;
               end
            end else begin
               baud_d = baud_q + 16'd1;
            end
         end
         default: begin
            state_d = StIdle;
            baud_d  = '0;
            bit_d   = '0;
         end
      endcase

      // Popping always starts a new frame with its start bit.
      if (pop) begin
         shift_d  = fifo_rdata;
         baud_d   = '0;
         bit_d    = '0;
         state_d  = StStart;
`ifdef UART_TX_PARITY_EN
         parity_d = ^fifo_rdata;
`endif
      end
   end

   // Line level for the upcoming cycle, derived from the next state so that
   // uart_tx lines up exactly with state_q.
   always_comb begin
      tx_d = 1'b1;
      unique case (state_d)
         StIdle:   tx_d = 1'b1;
         StStart:  tx_d = 1'b0;
         StData:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
         StParity: tx_d = parity_d;
`endif
         StStop:   tx_d = 1'b1;
         default:  tx_d = 1'b1;
      endcase
   end

   logic frame_active;
   assign frame_active = (state_q != StIdle);
   assign uart_tx      = tx_q;
   assign tx_busy      = !fifo_empty || frame_active;

   // ---------------------------------------------------------------------------
   // Read path
   // ---------------------------------------------------------------------------
   logic        rd_sel_q;
   logic [31:0] rd_data_q;
   logic [31:0] status_val;

   // Count field is 8 bits wide; a 256-deep full FIFO reports count 0 with full set.
   assign status_val = {16'h0000, 8'(count_q), 4'h0, ovf_q, frame_active, fifo_empty, fifo_full};

   // Read select and STATUS snapshot, one cycle behind the address. Reset selects
   // the (zeroed) MMIO register so mem_read1_data reads 0 during reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_sel_q  <= 1'b1;
         rd_data_q <= '0;
      end else begin
         rd_sel_q  <= rd_mmio;
         rd_data_q <= (rd_mmio && mem_read1_addr[2]) ? status_val : 32'h0;
      end
   end

   assign mem_read1_data = rd_sel_q ? rd_data_q : ram_read1_data;

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Testbench for uart_tx_mmio: decode/read-mux vector table plus hand-written
// sequences for framing, FIFO overflow, back-to-back frames and mid-frame reset.

module tb_uart_tx_mmio;

   localparam int unsigned Cpb  = 4;
   localparam logic [31:0] Base = 32'hFFFF_0000;
`ifdef UART_TX_PARITY_EN
   localparam int unsigned FrameBits = 11;
`else
   localparam int unsigned FrameBits = 10;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  mem_we;
   logic [31:0] mem_write_addr;
   logic [31:0] mem_write_data;
   logic [31:0] mem_read1_addr;
   logic [31:0] ram_read1_data;
   logic [31:0] mem_read1_data;
   logic [3:0]  ram_we;
   logic        uart_tx;
   logic        tx_busy;

   int n_checks = 0;
   int n_errors = 0;

   uart_tx_mmio #(
      .MMIO_BASE   (Base),
      .CLKS_PER_BIT(Cpb),
      .FIFO_DEPTH  (8)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .mem_we        (mem_we),
      .mem_write_addr(mem_write_addr),
      .mem_write_data(mem_write_data),
      .mem_read1_addr(mem_read1_addr),
      .ram_read1_data(ram_read1_data),
      .mem_read1_data(mem_read1_data),
      .ram_we        (ram_we),
      .uart_tx       (uart_tx),
      .tx_busy       (tx_busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  we;
      logic [31:0] waddr;
      logic [31:0] wdata;
      logic [31:0] raddr;
      logic [31:0] ram;
      logic [3:0]  exp_we;
      logic [31:0] exp_rd;
   } vec_t;

   vec_t vecs [9];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic drive_store(input logic [3:0] we, input logic [31:0] a, input logic [31:0] d);
      mem_we         = we;
      mem_write_addr = a;
      mem_write_data = d;
   endtask

   function automatic logic frame_bit(input logic [7:0] b, input int i);
      if (i == 0) return 1'b0;
      if (i <= 8) return b[i-1];
`ifdef UART_TX_PARITY_EN
      if (i == 9) return ^b;
`endif
      return 1'b1;
   endfunction

   // Called at the negedge where the start bit is first visible; returns at the
   // negedge just after the frame's last cycle. One comparison per bit period.
   task automatic expect_frame(input logic [7:0] b, input string tag);
      logic exp_bit;
      logic got;
      for (int i = 0; i < FrameBits; i++) begin
         exp_bit = frame_bit(b, i);
         got     = exp_bit;
         for (int c = 0; c < Cpb; c++) begin
            if (uart_tx !== exp_bit) got = uart_tx;
            @(negedge clk);
         end
         check($sformatf("%s bit%0d", tag, i), {31'b0, got}, {31'b0, exp_bit});
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      // {we, waddr, wdata, raddr, ram data, expected ram_we, expected read data}
      vecs[0] = '{4'hF, 32'h0000_1000, 32'h0,         32'h0000_1000, 32'hDEAD_BEEF, 4'hF, 32'hDEAD_BEEF};
      vecs[1] = '{4'h3, 32'h0000_2004, 32'h1,         32'h0000_2004, 32'h1234_5678, 4'h3, 32'h1234_5678};
      vecs[2] = '{4'hE, 32'hFFFF_0000, 32'hFFFF_FFFF, 32'hFFFF_0000, 32'hAAAA_AAAA, 4'h0, 32'h0};
      vecs[3] = '{4'h1, 32'hFFFF_0004, 32'h4,         32'hFFFF_0004, 32'h5555_5555, 4'h0, 32'h2};
      vecs[4] = '{4'h8, 32'hFFFF_0007, 32'hFF,        32'hFFFF_0007, 32'h7777_7777, 4'h0, 32'h2};
      vecs[5] = '{4'hF, 32'hFFFE_FFFC, 32'h0,         32'hFFFE_FFFC, 32'h0BAD_F00D, 4'hF, 32'h0BAD_F00D};
      vecs[6] = '{4'hC, 32'hFFFF_0008, 32'h0,         32'hFFFF_0008, 32'h600D_CAFE, 4'hC, 32'h600D_CAFE};
      vecs[7] = '{4'h0, 32'hFFFF_0003, 32'h0,         32'hFFFF_0003, 32'h1111_1111, 4'h0, 32'h0};
      vecs[8] = '{4'h1, 32'hFFFF_0004, 32'h8,         32'hFFFF_0000, 32'h2222_2222, 4'h0, 32'h0};

      rst_n          = 1'b0;
      mem_we         = 4'h0;
      mem_write_addr = 32'h0;
      mem_write_data = 32'h0;
      mem_read1_addr = 32'h0;
      ram_read1_data = 32'h0;
      repeat (3) @(negedge clk);
      check("reset uart_tx", uart_tx, 1);
      check("reset tx_busy", tx_busy, 0);
      check("reset rdata", mem_read1_data, 0);

      // Release; a store on the first edge is dropped, one on the second lands.
      rst_n = 1'b1;
      drive_store(4'b0001, Base, 32'hAA);
      @(negedge clk);
      check("push before sync dropped", tx_busy, 0);
      drive_store(4'b1111, Base, 32'h55);
      #1 check("ram_we mmio store", ram_we, 4'b0000);
      @(negedge clk);
      mem_we = 4'h0;
      check("busy after push", tx_busy, 1);
      check("idle before start", uart_tx, 1);
      @(negedge clk);
      expect_frame(8'h55, "f55");
      check("busy after frame", tx_busy, 0);

      // Decode and read-mux table, FIFO empty and transmitter idle.
      for (int i = 0; i < 9; i++) begin
         drive_store(vecs[i].we, vecs[i].waddr, vecs[i].wdata);
         mem_read1_addr = vecs[i].raddr;
         ram_read1_data = 32'h0;
         #1 check($sformatf("vec%0d ram_we", i), {28'b0, ram_we}, {28'b0, vecs[i].exp_we});
         @(negedge clk);
         mem_we         = 4'h0;
         ram_read1_data = vecs[i].ram;
         #1 check($sformatf("vec%0d rdata", i), mem_read1_data, vecs[i].exp_rd);
         @(negedge clk);
      end
      check("table left fifo empty", tx_busy, 0);

      // Burst: nine bytes accepted (one popped early), tenth overflows.
      fork
         begin : stores
            for (int k = 0; k < 10; k++) begin
               drive_store(4'b0001, Base, (k < 9) ? 32'(k) : 32'hEE);
               @(negedge clk);
            end
            mem_we         = 4'h0;
            mem_read1_addr = 32'hFFFF_0004;
            @(negedge clk);
            check("status overflow", mem_read1_data, 32'h0000_080D);
            drive_store(4'b0001, 32'hFFFF_0004, 32'h0);
            @(negedge clk);
            check("status hold a", mem_read1_data, 32'h0000_080D);
            drive_store(4'b0010, 32'hFFFF_0004, 32'h8);
            @(negedge clk);
            check("status no clear bit3=0", mem_read1_data, 32'h0000_080D);
            drive_store(4'b0001, 32'hFFFF_0004, 32'h8);
            @(negedge clk);
            check("status no clear lane1", mem_read1_data, 32'h0000_080D);
            mem_we = 4'h0;
            @(negedge clk);
            check("status overflow cleared", mem_read1_data, 32'h0000_0805);
         end
         begin : frames
            repeat (2) @(negedge clk);
            for (int k = 0; k < 9; k++) begin
               expect_frame(8'(k), $sformatf("burst%0d", k));
            end
         end
      join
      check("burst done busy", tx_busy, 0);
      check("burst done line", uart_tx, 1);

      // Reset in the middle of data bit 3 of 0xA5.
      mem_read1_addr = 32'hFFFF_0004;
      drive_store(4'b0001, Base, 32'hA5);
      @(negedge clk);
      mem_we = 4'h0;
      repeat (18) @(negedge clk);
      check("mid-frame bit3", uart_tx, 0);
      check("mid-frame status", mem_read1_data, 32'h0000_0006);
      rst_n = 1'b0;
      #1;
      check("mid reset uart_tx", uart_tx, 1);
      check("mid reset tx_busy", tx_busy, 0);
      check("mid reset rdata", mem_read1_data, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("status after reset", mem_read1_data, 32'h0000_0002);
      drive_store(4'b0001, Base, 32'h3C);
      @(negedge clk);
      mem_we = 4'h0;
      check("busy after reset push", tx_busy, 1);
      @(negedge clk);
      expect_frame(8'h3C, "f3c");
      check("idle after f3c", tx_busy, 0);

`ifdef UART_TX_PARITY_EN
      drive_store(4'b0001, Base, 32'h07);
      @(negedge clk);
      drive_store(4'b0001, Base, 32'h03);
      @(negedge clk);
      mem_we = 4'h0;
      expect_frame(8'h07, "par07");
      expect_frame(8'h03, "par03");
      check("idle after parity", tx_busy, 0);
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
